alu_exec_ctrl: RTL and testbench

Single-issue execute controller for the 8-bit datapath, wrapped around the combinational add/subtract ALU.
- Upstream, it accepts one register-to-register instruction at a time over a valid/ready handshake.
- It reads operands from an internal 4×8 register file and drives the ALU's `add_sub`, `X` and `Y` inputs from registers.
- Downstream, it captures the ALU's `Z` and overflow outputs, writes the result back, and keeps a sticky overflow flag.

---
 rtl/alu_exec_pkg.sv | 20 ++
 rtl/alu_exec_regfile.sv | 38 +++
 rtl/alu_exec_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants, opcodes and FSM encoding for the execute controller.
package alu_exec_pkg;

   localparam int DATA_W = 8;
   localparam int NREG   = 4;
   localparam int RA_W   = $clog2(NREG);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

endpackage

// File: rtl/alu_exec_regfile.sv
// NREG x DATA_W register file: one synchronous write port, three
// combinational read ports (two operands plus debug).
module alu_exec_regfile
   import alu_exec_pkg::*;
#(
   parameter int DATA_W = alu_exec_pkg::DATA_W,
   parameter int NREG   = alu_exec_pkg::NREG,
   parameter int RA_W   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [RA_W-1:0]   i_wa,
   input  logic [DATA_W-1:0] i_wd,
   input  logic [RA_W-1:0]   i_ra1,
   input  logic [RA_W-1:0]   i_ra2,
   input  logic [RA_W-1:0]   i_rad,
   output logic [DATA_W-1:0] o_rd1,
   output logic [DATA_W-1:0] o_rd2,
   output logic [DATA_W-1:0] o_rdd
);

   logic [NREG-1:0][DATA_W-1:0] r_mem;

   // storage: cleared on reset, single write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem <= '0;
      end else if (i_we) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = r_mem[i_ra1];
   assign o_rd2 = r_mem[i_ra2];
   assign o_rdd = r_mem[i_rad];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Single-issue execute controller: IDLE -> READ -> EXEC -> WB around an
// external combinational add/sub ALU. Operands and results are registered
// so the ALU sees stable inputs for a full cycle.
module alu_exec_ctrl
   import alu_exec_pkg::*;
#(
   parameter int DATA_W = alu_exec_pkg::DATA_W,
   parameter int NREG   = alu_exec_pkg::NREG,
   parameter int RA_W   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [RA_W-1:0]   instr_rd,
   input  logic [RA_W-1:0]   instr_rs1,
   input  logic [RA_W-1:0]   instr_rs2,
   input  logic [DATA_W-1:0] instr_imm,
   output logic              alu_add_sub,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   input  logic [DATA_W-1:0] alu_z,
   input  logic              alu_ofs,
   output logic              done,
   output logic              ovf_flag,
   input  logic              clear_ovf,
   input  logic [RA_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_t              r_state, w_nxt;
   logic [1:0]          r_op;
   logic [RA_W-1:0]     r_rd, r_rs1, r_rs2;
   logic [DATA_W-1:0]   r_imm;
   logic [DATA_W-1:0]   r_x, r_y, r_res;
   logic                r_add_sub, r_ofs, r_ovf;
   logic [DATA_W-1:0]   w_rs1_data, w_rs2_data;
   logic                w_idle, w_wb, w_arith, w_we;

   alu_exec_regfile #(.DATA_W(DATA_W), .NREG(NREG), .RA_W(RA_W)) u_rf (
      .clk   (clk),
      .rst   (rst),
      .i_we  (w_we),
      .i_wa  (r_rd),
      .i_wd  (r_res),
      .i_ra1 (r_rs1),
      .i_ra2 (r_rs2),
      .i_rad (dbg_addr),
      .o_rd1 (w_rs1_data),
      .o_rd2 (w_rs2_data),
      .o_rdd (dbg_data)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nxt;
   end

   // next state: fixed four-cycle walk once an instruction is accepted
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE: if (instr_valid) w_nxt = ST_READ;
         ST_READ: w_nxt = ST_EXEC;
         ST_EXEC: w_nxt = ST_WB;
         ST_WB:   w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   // state-decoded outputs and writeback strobes
   always_comb begin
      w_idle  = (r_state == ST_IDLE);
      w_wb    = (r_state == ST_WB);
      w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
      w_we    = w_wb && (r_op != OP_NOP);
   end

   // instruction latch, ALU operand/result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op      <= OP_ADD;
         r_rd      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_imm     <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_add_sub <= 1'b0;
         r_res     <= '0;
         r_ofs     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (instr_valid) begin
               r_op  <= instr_op;
               r_rd  <= instr_rd;
               r_rs1 <= instr_rs1;
               r_rs2 <= instr_rs2;
               r_imm <= instr_imm;
            end
            ST_READ: begin
               // LDI feeds imm + 0 through the adder; NOP leaves operands alone
               if (r_op == OP_ADD || r_op == OP_SUB) begin
                  r_x       <= w_rs1_data;
                  r_y       <= w_rs2_data;
                  r_add_sub <= r_op[0];
               end else if (r_op == OP_LDI) begin
                  r_x       <= r_imm;
                  r_y       <= '0;
                  r_add_sub <= 1'b0;
               end
            end
            ST_EXEC: begin
               r_res <= alu_z;
               r_ofs <= alu_ofs;
            end
            default: ;
         endcase
      end
   end

   // sticky overflow: a set in WB takes priority over a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       r_ovf <= 1'b0;
      else if (w_wb && w_arith && r_ofs) r_ovf <= 1'b1;
      else if (clear_ovf)            r_ovf <= 1'b0;
   end

   assign instr_ready = w_idle;
   assign done        = w_wb;
   assign alu_x       = r_x;
   assign alu_y       = r_y;
   assign alu_add_sub = r_add_sub;
   assign ovf_flag    = r_ovf;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl with a behavioural ALU attached.
module tb_alu_exec_ctrl;
   import alu_exec_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid, instr_ready;
   logic [1:0] instr_op, instr_rd, instr_rs1, instr_rs2;
   logic [7:0] instr_imm;
   logic       alu_add_sub;
   logic [7:0] alu_x, alu_y, alu_z;
   logic       alu_ofs;
   logic       done, ovf_flag, clear_ovf;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   typedef struct {
      logic [1:0] rd;
      logic [7:0] val;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_reg[4];
   logic       m_ovf;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   // reference ALU the controller drives
   assign alu_z   = alu_add_sub ? alu_x - alu_y : alu_x + alu_y;
   assign alu_ofs = alu_add_sub ? ((alu_x[7] != alu_y[7]) && (alu_z[7] != alu_x[7]))
                                : ((alu_x[7] == alu_y[7]) && (alu_z[7] != alu_x[7]));

   alu_exec_ctrl dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd),
      .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
      .alu_add_sub(alu_add_sub), .alu_x(alu_x), .alu_y(alu_y),
      .alu_z(alu_z), .alu_ofs(alu_ofs),
      .done(done), .ovf_flag(ovf_flag), .clear_ovf(clear_ovf),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // model: push the expected rd contents at drive time, update ovf model
   task automatic model_push(input logic [1:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic [7:0] imm, input bit clr_wb);
      exp_t e;
      int   sr;
      logic [7:0] v;
      bit   ov;
      ov = 1'b0;
      v  = m_reg[rd];
      if (op == OP_ADD || op == OP_SUB) begin
         sr = (op == OP_SUB) ? int'($signed(m_reg[rs1])) - int'($signed(m_reg[rs2]))
                             : int'($signed(m_reg[rs1])) + int'($signed(m_reg[rs2]));
         ov = (sr > 127) || (sr < -128);
         v  = sr[7:0];
      end else if (op == OP_LDI) begin
         v = imm;
      end
      if (op != OP_NOP) m_reg[rd] = v;
      if (ov) m_ovf = 1'b1;
      else if (clr_wb) m_ovf = 1'b0;
      e.rd = rd;
      e.val = v;
      exp_q.push_back(e);
   endtask

   // one instruction: starts and ends at a negedge with the DUT idle
   task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [7:0] imm, input bit clr_wb);
      exp_t e;
      int   k;
      k = 0;
      while (!instr_ready && k < 20) begin @(negedge clk); k++; end
      chk("ready_wait", instr_ready, 1);
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
      instr_imm = imm; instr_valid = 1'b1;
      model_push(op, rd, rs1, rs2, imm, clr_wb);
      @(posedge clk); #1 instr_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk); k++;
         if (k == 2 && (op == OP_ADD || op == OP_SUB))
            chk("addsub_exec", alu_add_sub, (op == OP_SUB));
         if (k == 2 && op == OP_LDI) chk("ldi_x", alu_x, imm);
      end while (!done && k < 10);
      chk("done_lat", k, 3);
      if (clr_wb) clear_ovf = 1'b1;
      e = exp_q.pop_front();
      dbg_addr = e.rd;
      @(negedge clk);
      clear_ovf = 1'b0;
      chk("dbg_wb", dbg_data, e.val);
      chk("ovf", ovf_flag, m_ovf);
      chk("ready_back", instr_ready, 1);
   endtask

   task automatic clr_idle();
      clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
      m_ovf = 1'b0;
      chk("clr_idle", ovf_flag, m_ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, last_acc, nacc, ndone;
      bit pend;
      exp_t e;
      rst = 1'b1; instr_valid = 1'b0; instr_op = OP_NOP; instr_rd = '0;
      instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; clear_ovf = 1'b0; dbg_addr = '0;
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_ovf = 1'b0;
      repeat (2) @(negedge clk);
      // reset state
      chk("rst_ready", instr_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf_flag, 0);
      chk("rst_dbg", dbg_data, 0);
      chk("rst_x", alu_x, 0);
      chk("rst_addsub", alu_add_sub, 0);
      rst = 1'b0;
      @(negedge clk);

      // reset mid-EXEC
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h55, 1'b0);
      instr_op = OP_LDI; instr_rd = 2'd1; instr_imm = 8'h11; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_ovf = 1'b0;
      @(negedge clk);
      chk("rst_nodone", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_after", instr_ready, 1);
      chk("rst_nodone2", done, 0);
      dbg_addr = 2'd1;
      #1 chk("rst_r1", dbg_data, 8'h00);
      @(negedge clk);

      // load and subtract
      issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b0);
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hE0, 1'b0);
      issue(OP_SUB, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
      // subtract to zero, rd == rs
      issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hAA, 1'b0);
      issue(OP_SUB, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0);
      // NOP writes nothing
      issue(OP_NOP, 2'd2, 2'd0, 2'd0, 8'h77, 1'b0);
      // signed overflow, sticky across a clean ADD
      issue(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h6A, 1'b0);
      issue(OP_ADD, 2'd3, 2'd3, 2'd3, 8'h00, 1'b0);
      issue(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0);
      // clear in idle, then clear coinciding with a setting WB
      clr_idle();
      issue(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h6A, 1'b0);
      issue(OP_ADD, 2'd3, 2'd3, 2'd3, 8'h00, 1'b1);
      clr_idle();
      // clear at WB of an op with no overflow
      issue(OP_ADD, 2'd1, 2'd1, 2'd1, 8'h00, 1'b1);

      // back-pressure: valid held high continuously
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h01, 1'b0);
      dbg_addr = 2'd1;
      instr_op = OP_ADD; instr_rd = 2'd1; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
      instr_valid = 1'b1;
      cyc = 0; last_acc = -1; nacc = 0; ndone = 0; pend = 1'b0;
      while ((ndone < 3 || pend) && cyc < 40) begin
         if (pend) begin
            chk("bp_dbg", dbg_data, e.val);
            pend = 1'b0;
         end
         if (instr_valid && instr_ready) begin
            if (last_acc >= 0) chk("bp_gap", cyc - last_acc, 4);
            last_acc = cyc;
            nacc++;
            model_push(OP_ADD, 2'd1, 2'd1, 2'd1, 8'h00, 1'b0);
         end
         if (done) begin
            ndone++;
            chk("bp_done_lat", cyc - last_acc, 3);
            e = exp_q.pop_front();
            pend = 1'b1;
            if (ndone == 3) instr_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      chk("bp_ndone", ndone, 3);
      chk("bp_nacc", nacc, 3);
      chk("bp_r1", m_reg[1], 8'h08);
      chk("bp_ovf", ovf_flag, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
